// File: rtl/core_pkg.sv
// Shared types and constants for the MEM-stage slice of the pipelined core.
// Holds the access state encoding and default data/register widths.
package core_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int REG_ADDR_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register feeding the write-back mux.
// A bubble clears the write enables and holds the data fields.
module mem_wb_reg
    import core_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  bubble_i,
    input  logic                  memtoreg_i,
    input  logic                  regwrite_i,
    input  logic [REG_ADDR_W-1:0] write_reg_i,
    input  logic [DATA_W-1:0]     read_data_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    output logic                  memtoreg_o,
    output logic                  regwrite_o,
    output logic [REG_ADDR_W-1:0] write_reg_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [DATA_W-1:0]     alu_result_o
);

    logic                  memtoreg_q;
    logic                  regwrite_q;
    logic [REG_ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0]     read_data_q;
    logic [DATA_W-1:0]     alu_result_q;

    // capture MEM fields, or insert a bubble while the stage is stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
        end else if (bubble_i) begin
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
        end else begin
            memtoreg_q   <= memtoreg_i;
            regwrite_q   <= regwrite_i;
            write_reg_q  <= write_reg_i;
            read_data_q  <= read_data_i;
            alu_result_q <= alu_result_i;
        end
    end

    assign memtoreg_o   = memtoreg_q;
    assign regwrite_o   = regwrite_q;
    assign write_reg_o  = write_reg_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: one data-memory access per load/store, stall and branch resolve.
// Optional access timeout with abort pulse is enabled by MEM_TIMEOUT_EN.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_MemtoReg,
    input  logic                  MEM_MemRead,
    input  logic                  MEM_MemWrite,
    input  logic                  MEM_Branch,
    input  logic                  MEM_RegWrite,
    input  logic                  MEM_zero_flag,
    input  logic [REG_ADDR_W-1:0] MEM_write_reg,
    input  logic [DATA_W-1:0]     MEM_alu_result,
    input  logic [DATA_W-1:0]     MEM_alu_result_pc,
    input  logic [DATA_W-1:0]     MEM_read_data2,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  stall,
    output logic                  pc_src,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  WB_MemtoReg,
    output logic                  WB_RegWrite,
    output logic [REG_ADDR_W-1:0] WB_write_reg,
    output logic [DATA_W-1:0]     WB_read_data,
    output logic [DATA_W-1:0]     WB_alu_result,
    output logic                  mem_err
);

    mem_state_e        state_q, state_d;
    logic              memop;
    logic              rsp_done;
    logic              timeout;
    logic              req_v;
    logic              stall_c;
    logic [DATA_W-1:0] rd_data;

    assign memop         = MEM_MemRead | MEM_MemWrite;
    assign dmem_addr     = MEM_alu_result;
    assign dmem_wdata    = MEM_read_data2;
    assign dmem_we       = MEM_MemWrite & ~MEM_MemRead;
    assign pc_src        = MEM_Branch & MEM_zero_flag;
    assign branch_target = MEM_alu_result_pc;
    assign rsp_done      = (state_q == RESP) & dmem_rsp_valid;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = (state_q != IDLE) & ~rsp_done
                   & (cnt_q == CNT_W'(TIMEOUT_CYC));

    // wait counter: zero while idle, counts every cycle spent in REQ/RESP
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (state_q == IDLE || timeout || rsp_done) begin
            cnt_d = '0;
        end
    end

    // wait counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC != 0);
    assign timeout    = 1'b0;
`endif

    // access state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, request valid and raw stall
    always_comb begin
        state_d = state_q;
        req_v   = 1'b0;
        stall_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_v   = memop;
                stall_c = memop;
                if (memop) begin
                    state_d = dmem_req_ready ? RESP : REQ;
                end
            end
            REQ: begin
                req_v   = 1'b1;
                stall_c = 1'b1;
                if (dmem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                stall_c = ~dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout) begin
            state_d = IDLE;
            req_v   = 1'b0;
            stall_c = 1'b0;
        end
    end

    assign dmem_req_valid = rst & req_v;
    assign stall          = rst & stall_c;
    assign mem_err        = rst & timeout;
    assign rd_data        = (rsp_done & MEM_MemRead) ? dmem_rdata : '0;

    mem_wb_reg #(
        .DATA_W (DATA_W)
    ) u_mem_wb_reg (
        .clk_i        (clk),
        .rst_ni       (rst),
        .bubble_i     (stall | timeout),
        .memtoreg_i   (MEM_MemtoReg),
        .regwrite_i   (MEM_RegWrite),
        .write_reg_i  (MEM_write_reg),
        .read_data_i  (rd_data),
        .alu_result_i (MEM_alu_result),
        .memtoreg_o   (WB_MemtoReg),
        .regwrite_o   (WB_RegWrite),
        .write_reg_o  (WB_write_reg),
        .read_data_o  (WB_read_data),
        .alu_result_o (WB_alu_result)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: random ops against a scoreboard.
// Timeout abort is exercised only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_MemtoReg, MEM_MemRead, MEM_MemWrite;
    logic          MEM_Branch, MEM_RegWrite, MEM_zero_flag;
    logic [4:0]    MEM_write_reg;
    logic [DW-1:0] MEM_alu_result, MEM_alu_result_pc, MEM_read_data2;
    logic          dmem_req_valid, dmem_req_ready, dmem_we;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_rsp_valid;
    logic [DW-1:0] dmem_rdata;
    logic          stall, pc_src;
    logic [DW-1:0] branch_target;
    logic          WB_MemtoReg, WB_RegWrite;
    logic [4:0]    WB_write_reg;
    logic [DW-1:0] WB_read_data, WB_alu_result;
    logic          mem_err;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W      (DW),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .MEM_MemtoReg      (MEM_MemtoReg),
        .MEM_MemRead       (MEM_MemRead),
        .MEM_MemWrite      (MEM_MemWrite),
        .MEM_Branch        (MEM_Branch),
        .MEM_RegWrite      (MEM_RegWrite),
        .MEM_zero_flag     (MEM_zero_flag),
        .MEM_write_reg     (MEM_write_reg),
        .MEM_alu_result    (MEM_alu_result),
        .MEM_alu_result_pc (MEM_alu_result_pc),
        .MEM_read_data2    (MEM_read_data2),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rdata        (dmem_rdata),
        .stall             (stall),
        .pc_src            (pc_src),
        .branch_target     (branch_target),
        .WB_MemtoReg       (WB_MemtoReg),
        .WB_RegWrite       (WB_RegWrite),
        .WB_write_reg      (WB_write_reg),
        .WB_read_data      (WB_read_data),
        .WB_alu_result     (WB_alu_result),
        .mem_err           (mem_err)
    );

    typedef struct {
        logic          regwrite;
        logic          memtoreg;
        logic [4:0]    wreg;
        logic [DW-1:0] alu;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive_idle();
        MEM_MemtoReg      = 1'b0;
        MEM_MemRead       = 1'b0;
        MEM_MemWrite      = 1'b0;
        MEM_Branch        = 1'b0;
        MEM_RegWrite      = 1'b0;
        MEM_zero_flag     = 1'b0;
        MEM_write_reg     = '0;
        MEM_alu_result    = '0;
        MEM_alu_result_pc = '0;
        MEM_read_data2    = '0;
        dmem_req_ready    = 1'b0;
        dmem_rsp_valid    = 1'b0;
        dmem_rdata        = '0;
    endtask

    // monitor: every edge with stall low retires one instruction into WB
    initial begin
        bit   was_stall;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            was_stall = stall;
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (was_stall) begin
                    check("bubble_regwrite", 32'(WB_RegWrite), 32'd0);
                    check("bubble_memtoreg", 32'(WB_MemtoReg), 32'd0);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected actual=retire required=none");
                end else begin
                    e = exp_q.pop_front();
                    check("wb_regwrite", 32'(WB_RegWrite), 32'(e.regwrite));
                    check("wb_memtoreg", 32'(WB_MemtoReg), 32'(e.memtoreg));
                    check("wb_write_reg", 32'(WB_write_reg), 32'(e.wreg));
                    check("wb_alu_result", WB_alu_result, e.alu);
                    check("wb_read_data", WB_read_data, e.rdata);
                end
            end
        end
    end

    // present one instruction (called at a negedge) until it leaves MEM.
    // r = cycles ready stays low, w = cycles between accept and response.
    task automatic run_op(input bit rd, input bit wr, input bit br,
                          input bit zf, input bit mtr, input bit rw,
                          input logic [4:0] wreg, input logic [31:0] alu,
                          input logic [31:0] pcv, input logic [31:0] d2,
                          input int r, input int w, input logic [31:0] rdat);
        int   k      = 0;
        int   stalls = 0;
        int   reqs   = 0;
        bit   memop  = rd | wr;
        bit   done   = 1'b0;
        exp_t e;
        MEM_MemRead       = rd;
        MEM_MemWrite      = wr;
        MEM_Branch        = br;
        MEM_zero_flag     = zf;
        MEM_MemtoReg      = mtr;
        MEM_RegWrite      = rw;
        MEM_write_reg     = wreg;
        MEM_alu_result    = alu;
        MEM_alu_result_pc = pcv;
        MEM_read_data2    = d2;
        while (!done) begin
            dmem_req_ready = memop && (k == r);
            if (memop) begin
                dmem_rsp_valid = (k == r + 1 + w)
                               || (k <= r && $urandom_range(3) == 0);
            end else begin
                dmem_rsp_valid = ($urandom_range(3) == 0);
            end
            dmem_rdata = (memop && k == r + 1 + w) ? rdat : $urandom;
            #1;
            if (k == 0) begin
                check("pc_src", 32'(pc_src), 32'(br & zf));
                check("branch_target", branch_target, pcv);
                check("dmem_we", 32'(dmem_we), 32'(wr & ~rd));
                check("mem_err_idle", 32'(mem_err), 32'd0);
            end
            if (dmem_req_valid) begin
                reqs++;
                check("req_addr", dmem_addr, alu);
                check("req_wdata", dmem_wdata, d2);
            end
            if (stall) stalls++;
            else done = 1'b1;
            if (!done && k > 60) begin
                checks++;
                failures++;
                $display("FAIL op_bound actual=stalled required=retire");
                done = 1'b1;
            end
            k++;
            if (!done) @(negedge clk);
        end
        check("stall_cycles", 32'(stalls), memop ? 32'(1 + r + w) : 32'd0);
        check("req_cycles", 32'(reqs), memop ? 32'(r + 1) : 32'd0);
        e.regwrite = rw;
        e.memtoreg = mtr;
        e.wreg     = wreg;
        e.alu      = alu;
        e.rdata    = (memop && rd) ? rdat : 32'd0;
        exp_q.push_back(e);
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
    endtask

    initial begin
        int kind;
        bit rd, wr, br, mtr, rw;
        drive_idle();
        rst = 1'b0;
        MEM_MemRead = 1'b1;
        #1;
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        check("rst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("rst_wb_alu", WB_alu_result, 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        drive_idle();
        rst = 1'b1;
        mon_en = 1'b1;

        run_op(0, 0, 0, 0, 0, 1, 5'd5, 32'h10, 32'h0, 32'h0, 0, 0, 0);
        run_op(1, 0, 0, 0, 1, 1, 5'd8, 32'h100, 32'h0, 32'h0,
               0, 0, 32'hDEADBEEF);
        run_op(0, 1, 0, 0, 0, 0, 5'd0, 32'h40, 32'h0, 32'h55,
               3, 2, 32'h0);
        run_op(0, 0, 1, 1, 0, 0, 5'd0, 32'h4, 32'h200, 32'h0, 0, 0, 0);
        run_op(0, 0, 1, 0, 0, 0, 5'd0, 32'h4, 32'h200, 32'h0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(4);
            rd  = (kind == 1 || kind == 4);
            wr  = (kind == 2 || kind == 4);
            br  = (kind == 3);
            mtr = rd;
            rw  = (kind == 0) ? 1'($urandom_range(1)) : rd;
            run_op(rd, wr, br, 1'($urandom_range(1)), mtr, rw,
                   5'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(4), $urandom_range(4), $urandom);
        end
        mon_en = 1'b0;
        drive_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        MEM_RegWrite   = 1'b1;
        MEM_write_reg  = 5'd7;
        MEM_alu_result = 32'h1234;
        @(negedge clk);
        MEM_MemRead    = 1'b1;
        MEM_MemtoReg   = 1'b1;
        MEM_write_reg  = 5'd9;
        MEM_alu_result = 32'h300;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        check("resp_stall", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("arst_wb_regwrite", 32'(WB_RegWrite), 32'd0);
        check("arst_wb_memtoreg", 32'(WB_MemtoReg), 32'd0);
        check("arst_wb_write_reg", 32'(WB_write_reg), 32'd0);
        check("arst_wb_alu", WB_alu_result, 32'd0);
        check("arst_wb_read_data", WB_read_data, 32'd0);
        @(negedge clk);
        drive_idle();
        rst            = 1'b1;
        MEM_RegWrite   = 1'b1;
        MEM_write_reg  = 5'd3;
        MEM_alu_result = 32'h77;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'hBAD0BAD0;
        #1;
        check("late_rsp_stall", 32'(stall), 32'd0);
        check("late_rsp_req", 32'(dmem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        check("late_rsp_read_data", WB_read_data, 32'd0);
        check("late_rsp_regwrite", 32'(WB_RegWrite), 32'd1);
        check("late_rsp_write_reg", 32'(WB_write_reg), 32'd3);
        @(negedge clk);
        drive_idle();

`ifdef MEM_TIMEOUT_EN
        begin
            int k_err  = -1;
            int stalls = 0;
            MEM_MemRead   = 1'b1;
            MEM_MemtoReg  = 1'b1;
            MEM_RegWrite  = 1'b1;
            MEM_write_reg = 5'd4;
            for (int k = 0; k < 40 && k_err < 0; k++) begin
                dmem_req_ready = (k == 0);
                #1;
                if (mem_err) k_err = k;
                else if (stall) stalls++;
                if (k_err < 0) @(negedge clk);
            end
            check("tmo_err_cycle", 32'(k_err), 32'd16);
            check("tmo_stall_cycles", 32'(stalls), 32'd16);
            check("tmo_stall_drop", 32'(stall), 32'd0);
            @(posedge clk);
            #1;
            check("tmo_squash", 32'(WB_RegWrite), 32'd0);
            @(negedge clk);
            drive_idle();
            #1;
            check("tmo_err_pulse", 32'(mem_err), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
